// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC injection arbiter.
package noc_arb_pkg;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned TIMEOUT_DEF   = 8;
   // Wide enough for any MAX_BURST up to 15
   localparam int unsigned BEAT_W        = 4;

   // Index width for n requesters, never below one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick
   import noc_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   // Walk offsets from highest to lowest so the smallest offset wins
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] pos;
      any = 1'b0;
      idx = '0;
      sum = '0;
      pos = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
         end
         pos = sum[IDX_W-1:0];
         if (req[pos]) begin
            any = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Burst-locked round-robin arbiter driving the rank-0 NoC injection FIFO.
// Optional idle-timeout abort enabled by defining NOC_ARB_TIMEOUT_EN.
module noc_inject_arbiter
   import noc_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = MAX_BURST_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
   localparam int unsigned IDX_W     = idx_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy,
   output logic                          abort
);

   // Reject out-of-range configurations at elaboration
   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 || TIMEOUT < 1)
   begin : g_bad_cfg
      $error("noc_inject_arbiter: parameter out of range");
   end

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [IDX_W-1:0]  next_ptr;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              xfer;

`ifdef NOC_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] idle_q, idle_d;
   logic            abort_q, abort_d;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
   assign grant_id = grant_q;
   assign busy     = (state_q == BURST);

   // Next-state, counters and FIFO-side handshake
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      beat_d    = beat_q;
      req_ready = '0;
      fifo_w_en = 1'b0;
      fifo_data = '0;
      xfer      = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
      idle_d    = idle_q;
      abort_d   = 1'b0;
`endif
      case (state_q)
         ARB: begin
            if (pick_any) begin
               grant_d = pick_idx;
               beat_d  = '0;
               state_d = BURST;
`ifdef NOC_ARB_TIMEOUT_EN
               idle_d  = '0;
`endif
            end
         end
         BURST: begin
            req_ready[grant_q] = !fifo_full;
            xfer      = req_valid[grant_q] & !fifo_full;
            fifo_w_en = xfer;
            fifo_data = req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            if (xfer) begin
               beat_d = beat_q + BEAT_W'(1);
`ifdef NOC_ARB_TIMEOUT_EN
               idle_d = '0;
`endif
               if (req_last[grant_q] || beat_q == BEAT_W'(MAX_BURST - 1)) begin
                  ptr_d   = next_ptr;
                  state_d = ARB;
               end
            end
`ifdef NOC_ARB_TIMEOUT_EN
            // Stalled cycles with valid high neither count nor clear
            else if (!req_valid[grant_q]) begin
               if (idle_q == TO_W'(TIMEOUT - 1)) begin
                  idle_d  = '0;
                  abort_d = 1'b1;
                  ptr_d   = next_ptr;
                  state_d = ARB;
               end else begin
                  idle_d = idle_q + TO_W'(1);
               end
            end
`endif
         end
         default: state_d = ARB;
      endcase
   end

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         grant_q <= '0;
         ptr_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
      end
   end

`ifdef NOC_ARB_TIMEOUT_EN
   // Idle counter and registered abort pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         idle_q  <= idle_d;
         abort_q <= abort_d;
      end
   end

   assign abort = abort_q;
`else
   assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4, TIMEOUT=8).
module tb_noc_inject_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic [NR-1:0]  req_valid;
   logic [NR-1:0]  req_last;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]  req_ready;
   logic           fifo_full;
   logic           fifo_w_en;
   logic [DW-1:0]  fifo_data;
   logic [1:0]     grant_id;
   logic           busy;
   logic           abort;

   noc_inject_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (4),
      .TIMEOUT    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_w_en (fifo_w_en),
      .fifo_data (fifo_data),
      .grant_id  (grant_id),
      .busy      (busy),
      .abort     (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_abort  = 0;
   int          n_wr     = 0;
   exp_t        exp_q[$];
   int          wcyc[$];
   logic [NR-1:0] acc;

   // Per-requester word sources
   logic [7:0]  src_data [NR][16];
   logic        src_last [NR][16];
   int          src_len  [NR];
   int          src_pos  [NR];

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         req_valid[r] = (src_pos[r] < src_len[r]);
         req_data[r*DW +: DW] = req_valid[r] ? src_data[r][src_pos[r]] : 8'h00;
         req_last[r] = req_valid[r] ? src_last[r][src_pos[r]] : 1'b0;
      end
   endtask

   task automatic load(input int r, input logic [7:0] base, input int n, input bit last_end);
      for (int i = 0; i < n; i++) begin
         src_data[r][i] = base + 8'(i);
         src_last[r][i] = last_end && (i == n - 1);
      end
      src_len[r] = n;
      src_pos[r] = 0;
      drive();
   endtask

   task automatic clear_sources();
      for (int r = 0; r < NR; r++) begin
         src_len[r] = 0;
         src_pos[r] = 0;
      end
      drive();
   endtask

   // Scoreboard: every FIFO write must match the head of exp_q
   task automatic monitor();
      exp_t e;
      acc = req_valid & req_ready;
      if (abort === 1'b1) n_abort++;
      if (fifo_w_en === 1'b1) begin
         n_wr++;
         wcyc.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got id=%0d data=%h, expected no write", grant_id, fifo_data);
         end else begin
            e = exp_q.pop_front();
            if (grant_id !== e.id || fifo_data !== e.data) begin
               n_fail++;
               $display("FAIL write_data: got id=%0d data=%h, expected id=%0d data=%h",
                        grant_id, fifo_data, e.id, e.data);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      for (int r = 0; r < NR; r++) if (acc[r]) src_pos[r]++;
      drive();
   endtask

   task automatic expect_words(input logic [1:0] id, input logic [7:0] base, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.id = id;
         e.data = base + 8'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fifo_full = 1'b0;
      clear_sources();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fifo_full = 1'b0;
      for (int r = 0; r < NR; r++) load(r, 8'(8'h10 * r), 4, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (fifo_w_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd0 ||
          fifo_data !== 8'h00 || abort !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got w_en=%b busy=%b ready=%b gid=%0d data=%h abort=%b, expected all 0",
                  fifo_w_en, busy, req_ready, grant_id, fifo_data, abort);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fifo_w_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_arb_cycle: got w_en=%b busy=%b, expected 0 0", fifo_w_en, busy);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || fifo_w_en !== 1'b1 ||
          fifo_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_first_grant: got busy=%b gid=%0d ready=%b w_en=%b data=%h, expected 1 0 0001 1 00",
                  busy, grant_id, req_ready, fifo_w_en, fifo_data);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      load(0, 8'hA0, 8, 1'b0);
      load(2, 8'hC0, 4, 1'b0);
      wcyc.delete();
      expect_words(2'd0, 8'hA0, 4);
      expect_words(2'd2, 8'hC0, 4);
      expect_words(2'd0, 8'hA4, 4);
      drain("rr", 40);
      repeat (3) tick();
      n_checks++;
      if (wcyc.size() != 12) begin
         n_fail++;
         $display("FAIL rr_count: got %0d writes, expected 12", wcyc.size());
      end else begin
         if (wcyc[3] - wcyc[0] != 3 || wcyc[4] - wcyc[3] != 2 || wcyc[8] - wcyc[7] != 2 ||
             wcyc[11] - wcyc[8] != 3) begin
            n_fail++;
            $display("FAIL rr_bubble: got gaps %0d %0d %0d %0d, expected 3 2 2 3",
                     wcyc[3] - wcyc[0], wcyc[4] - wcyc[3], wcyc[8] - wcyc[7], wcyc[11] - wcyc[8]);
         end
      end
   endtask

   task automatic test_last();
      do_reset();
      src_data[1][0] = 8'h11; src_last[1][0] = 1'b0;
      src_data[1][1] = 8'h22; src_last[1][1] = 1'b1;
      src_len[1] = 2; src_pos[1] = 0;
      drive();
      expect_words(2'd1, 8'h11, 1);
      expect_words(2'd1, 8'h22, 1);
      drain("last", 10);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin
         n_fail++;
         $display("FAIL last_to_arb: got busy=%b w_en=%b, expected 0 0", busy, fifo_w_en);
      end
      @(posedge clk);
      #1;
      // Pointer now at 2: req 2 must beat req 1
      load(1, 8'h33, 1, 1'b1);
      load(2, 8'h44, 1, 1'b1);
      expect_words(2'd2, 8'h44, 1);
      expect_words(2'd1, 8'h33, 1);
      drain("last_ptr", 12);
   endtask

   task automatic test_stall();
      int k = 0;
      int base;
      do_reset();
      load(3, 8'h30, 4, 1'b1);
      expect_words(2'd3, 8'h30, 4);
      base = n_wr;
      while (n_wr < base + 2 && k < 12) begin
         tick();
         k++;
      end
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready !== 4'b0 || fifo_w_en !== 1'b0 || fifo_data !== 8'h32 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_%0d: got ready=%b w_en=%b data=%h busy=%b, expected 0000 0 32 1",
                     i, req_ready, fifo_w_en, fifo_data, busy);
         end
         @(posedge clk);
         #1;
      end
      fifo_full = 1'b0;
      drain("stall", 10);
   endtask

   task automatic test_timeout();
      int k = 0;
      do_reset();
      n_abort = 0;
      load(3, 8'h3A, 1, 1'b0);
      expect_words(2'd3, 8'h3A, 1);
      while (busy !== 1'b1 && k < 6) begin
         tick();
         k++;
      end
      load(0, 8'h0B, 1, 1'b1);
      drain("to_first", 6);
`ifdef NOC_ARB_TIMEOUT_EN
      expect_words(2'd0, 8'h0B, 1);
      drain("to_regrant", 20);
      repeat (2) tick();
      n_checks++;
      if (n_abort != 1) begin
         n_fail++;
         $display("FAIL to_abort_count: got %0d pulses, expected 1", n_abort);
      end
`else
      repeat (14) tick();
      n_checks++;
      if (busy !== 1'b1 || grant_id !== 2'd3 || n_abort != 0) begin
         n_fail++;
         $display("FAIL to_hold: got busy=%b gid=%0d aborts=%0d, expected 1 3 0", busy, grant_id, n_abort);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int base;
      do_reset();
      load(0, 8'h50, 4, 1'b1);
      expect_words(2'd0, 8'h50, 2);
      base = n_wr;
      while (n_wr < base + 2 && k < 10) begin
         tick();
         k++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (fifo_w_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || fifo_data !== 8'h00 ||
          grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: got w_en=%b busy=%b ready=%b data=%h gid=%0d, expected all 0",
                  fifo_w_en, busy, req_ready, fifo_data, grant_id);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      load(2, 8'h60, 1, 1'b1);
      expect_words(2'd0, 8'h52, 2);
      expect_words(2'd2, 8'h60, 1);
      drain("reset_mid", 16);
      repeat (2) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      fifo_full = 1'b0;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      acc = '0;
      clear_sources();
      test_reset();
      test_round_robin();
      test_last();
      test_stall();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
